// File: rtl/inst_encode_if.sv
// Handshake bundle between an op producer (master) and the instruction encoder FIFO (slave).
// Count width follows DEPTH so that a full FIFO (count == DEPTH) is representable.
interface inst_encode_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_name;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_illegal;
    logic [CNT_W-1:0] count;
    logic [7:0]       illegal_cnt;

    modport slave (
        input  flush, in_valid, in_name, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_illegal, count, illegal_cnt
    );

    modport master (
        output flush, in_valid, in_name, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_illegal, count, illegal_cnt
    );
endinterface

// File: rtl/inst_encode.sv
// Re-encodes decoded ops into RV32I instruction words and buffers them in a DEPTH-entry FIFO.
// Op codes mirror the Decode stage constants (ADD=1 .. JALR=9); anything else is illegal.
module inst_encode #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_encode_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd3;
    localparam logic [5:0] OP_SW    = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_LUI   = 6'd6;
    localparam logic [5:0] OP_AUIPC = 6'd7;
    localparam logic [5:0] OP_JAL   = 6'd8;
    localparam logic [5:0] OP_JALR  = 6'd9;

    typedef struct packed {
        logic        illegal;
        logic [31:0] inst;
    } entry_t;

    entry_t           wr_entry;
    entry_t           head;
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       illegal_cnt;
    logic             out_valid;
    logic             in_ready;
    logic             push;
    logic             pop;

    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        i_ok;
    logic        b_ok;
    logic        j_ok;
    logic        u_ok;

    assign imm = bus.in_imm;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;

    // Immediate must be exactly what Decode would have produced from the encoded fields.
    assign i_ok = (imm[31:11] == {21{imm[11]}});
    assign b_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    assign j_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
    assign u_ok = (imm[11:0] == 12'h000);

    always_comb begin
        wr_entry = '0;
        unique case (bus.in_name)
            OP_ADD:   wr_entry.inst = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            OP_SUB:   wr_entry.inst = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            OP_LW: begin
                wr_entry.inst    = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
                wr_entry.illegal = !i_ok;
            end
            OP_SW: begin
                wr_entry.inst    = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
                wr_entry.illegal = !i_ok;
            end
            OP_BEQ: begin
                wr_entry.inst    = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
                wr_entry.illegal = !b_ok;
            end
            OP_LUI: begin
                wr_entry.inst    = {imm[31:12], rd, 7'b0110111};
                wr_entry.illegal = !u_ok;
            end
            OP_AUIPC: begin
                wr_entry.inst    = {imm[31:12], rd, 7'b0010111};
                wr_entry.illegal = !u_ok;
            end
            OP_JAL: begin
                wr_entry.inst    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                wr_entry.illegal = !j_ok;
            end
            OP_JALR: begin
                wr_entry.inst    = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
                wr_entry.illegal = !i_ok;
            end
            default:  wr_entry.illegal = 1'b1;
        endcase
        if (wr_entry.illegal) begin
            wr_entry.inst = '0;
        end
    end

    // A pop frees a slot on the same edge, so a full FIFO can still accept while draining.
    assign out_valid = (count != '0);
    assign in_ready  = rst_n && !bus.flush && ((count < FULL) || (out_valid && bus.out_ready));
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready && !bus.flush;

    // NOTE: the storage array has no reset; the head is gated by out_valid instead, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            illegal_cnt <= '0;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
            if (push && wr_entry.illegal && (illegal_cnt != 8'hFF)) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

    assign head            = mem[rd_ptr];
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_inst    = out_valid ? head.inst : 32'h0000_0000;
    assign bus.out_illegal = out_valid && head.illegal;
    assign bus.count       = count;
    assign bus.illegal_cnt = illegal_cnt;
endmodule
